// File: rtl/burst_write_block_if.sv
// IPIF master-burst write bus bundle between burst_write_block and the IPIF.
interface burst_write_block_if;
  logic [31:0] ip2bus_mst_addr;
  logic [11:0] ip2bus_mst_length;
  logic [31:0] ip2bus_mstwr_d;
  logic [4:0]  ip2bus_inputs;
  logic [5:0]  ip2bus_otputs;

  modport master (
    output ip2bus_mst_addr,
    output ip2bus_mst_length,
    output ip2bus_mstwr_d,
    output ip2bus_inputs,
    input  ip2bus_otputs
  );

  modport slave (
    input  ip2bus_mst_addr,
    input  ip2bus_mst_length,
    input  ip2bus_mstwr_d,
    input  ip2bus_inputs,
    output ip2bus_otputs
  );
endinterface

// File: rtl/burst_write_block.sv
// FIFO-fed IPIF burst-write master into a circular DDR frame buffer.
// Define BURST_WRITE_FLUSH_EN to add the flush input for short bursts.
module burst_write_block #(
  parameter int          BURST_WORDS   = 20,
  parameter logic [31:0] BASE_ADDR     = 32'h0020_0000,
  parameter logic [31:0] FRAME_BYTES   = 32'h0004_B000,
  parameter int          ADDRESS_WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        restart,
`ifdef BURST_WRITE_FLUSH_EN
  input  logic        flush,
`endif
  input  logic        write,
  input  logic [31:0] write_data,
  output logic        full,
  output logic [12:0] count_in_buf,
  output logic        err_sticky,
  burst_write_block_if.master bus
);

  localparam int          DEPTH    = 1 << ADDRESS_WIDTH;
  localparam logic [7:0]  BW       = 8'(BURST_WORDS);
  localparam logic [31:0] END_ADDR = BASE_ADDR + FRAME_BYTES;

  typedef enum logic [1:0] {
    IDLE, REQ, XFER, WAIT_CMPLT
  } state_t;

  state_t state_q, state_d;

  logic [31:0] mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [12:0] cnt;
  logic [31:0] addr_q, addr_nxt;
  logic [7:0]  len_q, words_left, load_len;
  logic        pend;

  logic cmdack, cmplt, error, dst_rdy_n;
  logic req, typ, sof_n, eof_n, src_rdy_n;
  logic load, beat, done, push, apply_rst;
  logic unused;

  assign cmdack    = bus.ip2bus_otputs[0];
  assign cmplt     = bus.ip2bus_otputs[1];
  assign error     = bus.ip2bus_otputs[2];
  assign dst_rdy_n = bus.ip2bus_otputs[3];
  assign unused    = ^bus.ip2bus_otputs[5:4];

  always_comb begin
    state_d   = state_q;
    req       = 1'b0;
    typ       = 1'b0;
    sof_n     = 1'b1;
    eof_n     = 1'b1;
    src_rdy_n = 1'b1;
    load      = 1'b0;
    load_len  = BW;
    beat      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!restart) begin
          if (cnt >= 13'(BURST_WORDS)) begin
            state_d = REQ;
            load    = 1'b1;
          end
`ifdef BURST_WRITE_FLUSH_EN
          else if (flush && cnt != 13'd0) begin
            state_d  = REQ;
            load     = 1'b1;
            load_len = cnt[7:0];
          end
`endif
        end
      end
      REQ: begin
        req = 1'b1;
        typ = 1'b1;
        if (cmdack) state_d = XFER;
      end
      XFER: begin
        src_rdy_n = (cnt == 13'd0);
        sof_n     = !(words_left == len_q);
        eof_n     = !(words_left == 8'd1);
        beat      = !src_rdy_n && !dst_rdy_n;
        if (beat && words_left == 8'd1)
          state_d = WAIT_CMPLT;
      end
      WAIT_CMPLT: begin
        if (cmplt) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign full = (cnt == 13'(DEPTH));
  assign push = write && !full;
  assign addr_nxt = addr_q + 32'({len_q, 2'b00});
  // A pending restart replaces the address advance on cmplt.
  assign apply_rst = (state_q == IDLE && restart)
                   || (done && (pend || restart));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      addr_q     <= BASE_ADDR;
      len_q      <= BW;
      words_left <= '0;
      err_sticky <= 1'b0;
      pend       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (apply_rst) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        cnt        <= '0;
        addr_q     <= BASE_ADDR;
        err_sticky <= 1'b0;
        pend       <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (beat) rd_ptr <= rd_ptr + 1'b1;
        cnt <= cnt + 13'(push) - 13'(beat);
        if (restart && state_q != IDLE) pend <= 1'b1;
        if (done) begin
          addr_q <= (addr_nxt == END_ADDR) ? BASE_ADDR
                                           : addr_nxt;
          if (error) err_sticky <= 1'b1;
        end
      end
      if (load) begin
        len_q      <= load_len;
        words_left <= load_len;
      end
      if (beat) words_left <= words_left - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= write_data;
  end

  assign count_in_buf = cnt;
  assign bus.ip2bus_mst_addr   = addr_q;
  assign bus.ip2bus_mst_length = {2'b00, len_q, 2'b00};
  assign bus.ip2bus_mstwr_d    = (cnt == 13'd0) ? 32'd0
                                                : mem[rd_ptr];
  assign bus.ip2bus_inputs = {src_rdy_n, eof_n, sof_n, typ, req};

endmodule

// File: doc/burst_write_block.md
# burst_write_block

Streaming AXI burst-write master for the VGA/C64 frame path: the producer pushes 32-bit words into an internal FIFO, and the block drains them as fixed-length IPIF master bursts. It targets a circular frame buffer in DDR and sits between the pixel producer and the AXI master-burst IPIF. It is the write-direction counterpart to the burst read path and uses the same `ip2bus_inputs`/`ip2bus_otputs` bundle convention.

## Interface
- `BURST_WORDS`, 20: words per burst (1..255); `ip2bus_mst_length` = `BURST_WORDS*4` bytes.
- `BASE_ADDR`, 32'h0020_0000: first burst address; also the restart/wrap address.
- `FRAME_BYTES`, 32'h0004_B000: buffer size; must be a multiple of `BURST_WORDS*4`.
- `ADDRESS_WIDTH`, 8: FIFO depth is 2^ADDRESS_WIDTH words.
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `restart` in 1: synchronous request to flush the FIFO and rewind the address to `BASE_ADDR`.
- `write` in 1: producer push strobe.
- `write_data` in 32: producer word.
- `full` out 1: FIFO full.
- `count_in_buf` out 13: FIFO occupancy.
- `err_sticky` out 1: set by a completion that reports an error; cleared by `reset` or an applied restart.
- `ip2bus_mst_addr` out 32: burst start address.
- `ip2bus_mst_length` out 12: burst length in bytes.
- `ip2bus_mstwr_d` out 32: FIFO head word (first-word fall-through).
- `ip2bus_inputs` out 5: [0] mstwr_req, [1] mst_type (1 = burst), [2] sof_n, [3] eof_n, [4] src_rdy_n.
- `ip2bus_otputs` in 6: [0] cmdack, [1] cmplt, [2] error, [3] dst_rdy_n, [4] dst_dsc_n (ignored), [5] md_error (ignored).

## Operation
- **FIFO**
  - A push happens when `write & !full`; a push while full is dropped and the count is unchanged.
  - A pop happens on a beat, defined as `state==XFER & !src_rdy_n & !dst_rdy_n`.
  - A push and a pop in the same cycle leave `count_in_buf` unchanged.
- **FSM states**
  - IDLE: go to REQ when `count_in_buf >= BURST_WORDS`; load `words_left = BURST_WORDS`.
  - REQ: mstwr_req=1, mst_type=1. On cmdack, go to XFER.
  - XFER:
    - src_rdy_n = `(count_in_buf==0)`.
    - sof_n = 0 while `words_left==BURST_WORDS`.
    - eof_n = 0 while `words_left==1`.
    - Each beat decrements `words_left`. The beat taken at `words_left==1` moves to WAIT_CMPLT.
  - WAIT_CMPLT: on cmplt, go to IDLE.
    - Advance the address by `BURST_WORDS*4`.
    - If the result equals `BASE_ADDR+FRAME_BYTES`, the address wraps to `BASE_ADDR`.
    - If error=1 in the same cycle, set `err_sticky`.
- **Control outputs outside these states:** req=0, mst_type=0, sof_n=1, eof_n=1, src_rdy_n=1.
- **Restart**
  - In IDLE: applied immediately. FIFO is cleared, count=0, address=`BASE_ADDR`, `err_sticky`=0.
  - Outside IDLE: latched as `restart_pend`. The current burst finishes normally and pend is applied on the cmplt cycle, replacing the address advance.
  - Pushes while pend is set are accepted, then discarded when pend is applied.
- **Reset mid-burst:** immediate abort. State=IDLE, FIFO empty, address=`BASE_ADDR`, all control outputs inactive. The bus side is not notified.
- **Reset values**
  - `count_in_buf`=0, `full`=0, `err_sticky`=0.
  - `ip2bus_mst_addr`=`BASE_ADDR`, `ip2bus_mst_length`=`BURST_WORDS*4`.
  - `ip2bus_inputs`=5'b11100.
  - `ip2bus_mstwr_d`=0.

## Timing
- Push to `count_in_buf` update: 1 cycle.
- Push to head visible on `ip2bus_mstwr_d` when the FIFO was empty: 1 cycle.
- Threshold reached in IDLE: REQ starts on the next cycle.
- cmdack: sampled on a rising edge; XFER starts the following cycle.
- Address and length are stable from REQ entry until cmplt.
- Throughput: peak rate is 1 beat per cycle with dst_rdy_n held low.
- dst_rdy_n high stalls a beat; sof_n, eof_n and data hold until the beat is accepted.
- A FIFO underrun mid-burst drives src_rdy_n=1; the burst resumes when data arrives. No timeout.
- Simultaneous cmplt and restart in WAIT_CMPLT: restart wins and the address goes to `BASE_ADDR`.

## Configuration
- `BURST_WRITE_FLUSH_EN`, when defined:
  - Adds input `flush` (1 bit).
  - In IDLE, with `flush=1` and `0 < count_in_buf < BURST_WORDS`, issue a short burst of exactly `count_in_buf` words. Length = words*4; sof_n/eof_n follow the short count.
  - The address advances by the short length.
- When not defined: the port is absent, and residual words wait until the threshold is met.

## Test plan
- **Basic burst:** push 20 words 0x1..0x14 with cmdack after 2 cycles and dst_rdy_n=0 -> one burst at 0x200000, length 80, 20 beats in consecutive cycles. sof_n low on the 0x1 beat, eof_n low on the 0x14 beat; after cmplt the address is 0x200050.
- **Backpressure:** same stimulus with dst_rdy_n toggling every cycle -> 20 beats, data in order, no loss or duplication, `count_in_buf` returns to 0.
- **Wrap:** FRAME_BYTES=160, push 60 words -> bursts at 0x200000, 0x200050, then 0x200000.
- **Restart mid-burst:** restart pulse at beat 5 with 10 more words pushed -> burst completes all 20 beats, then address=0x200000, count=0, no new request.
- **Full/simultaneous:** fill 256 words with cmdack withheld, push 1 more -> dropped, count=256. During XFER, push and beat in the same cycle -> count unchanged.
- **Flush (BURST_WRITE_FLUSH_EN):** push 7 words and assert flush -> length 28, 7 beats, eof_n on the 7th beat, address advances by 0x1C.
